// File: rtl/omem_pkg.sv
// Shared definitions for the input/output memory blocks.
// Holds the unit/bank geometry, the derived address widths, the drain FSM
// state type and a helper that forms a flat unit address.
package omem_pkg;

    localparam int unsigned DW     = 4;          // bits per unit (nibble)
    localparam int unsigned NW     = 32;         // units per word/bank
    localparam int unsigned NB     = 4;          // number of banks
    localparam int unsigned WW     = DW * NW;    // word width (128)
    localparam int unsigned BANK_W = $clog2(NB); // bank index width
    localparam int unsigned UNIT_W = $clog2(NW); // unit index width
    localparam int unsigned ADDR_W = BANK_W + UNIT_W;

    typedef logic [WW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } omem_state_t;

    // Flat unit address {bank, unit}.
    function automatic logic [ADDR_W-1:0] unit_addr(input logic [BANK_W-1:0] bank,
                                                    input logic [UNIT_W-1:0] unit);
        return {bank, unit};
    endfunction

endpackage

// File: rtl/omem_nib_serializer.sv
// nib_serializer: captures one full word and presents it one unit at a time,
// lowest unit first.
//   clock      in   clock, posedge
//   reset_n    in   asynchronous active-low reset
//   load       in   capture load_data, restart at unit 0
//   load_data  in   word to serialise
//   shift      in   advance to the next unit
//   nib        out  current unit
//   unit       out  index of current unit
//   last       out  current unit is the final one of the word
module nib_serializer
    import omem_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  word_t             load_data,
    input  logic              shift,
    output logic [DW-1:0]     nib,
    output logic [UNIT_W-1:0] unit,
    output logic              last
);

    word_t shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            unit  <= '0;
        end else if (load) begin
            shreg <= load_data;
            unit  <= '0;
        end else if (shift) begin
            shreg <= shreg >> DW;
            unit  <= unit + UNIT_W'(1);
        end
    end

    assign nib  = shreg[DW-1:0];
    assign last = (unit == UNIT_W'(NW - 1));

endmodule

// File: rtl/omem.sv
// omem: output memory block. The compute array writes whole result words into
// NB banks; on start, all banks are drained in order (bank 0 unit 0 first) as
// a valid/ready stream of single units tagged with their flat address.
//   clock      in   clock, posedge
//   reset_n    in   asynchronous active-low reset (memory array not reset)
//   wr         in   write strobe, wdata -> bank waddr (accepted in any state)
//   waddr      in   bank written
//   wdata      in   word; unit k = wdata[4k+3:4k]
//   start      in   begin a drain (ignored while busy)
//   out_valid  out  odata/oaddr hold a valid unit
//   out_ready  in   consumer accepts unit when out_valid & out_ready
//   odata      out  current unit
//   oaddr      out  {bank, unit} of odata
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse after the last unit is accepted
module omem
    import omem_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [BANK_W-1:0] waddr,
    input  word_t             wdata,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     odata,
    output logic [ADDR_W-1:0] oaddr,
    output logic              busy,
    output logic              done
);

    word_t             memblock [NB];

    omem_state_t       state;
    omem_state_t       state_next;
    logic [BANK_W-1:0] bank;
    logic [BANK_W-1:0] bank_next;
    logic              done_next;

    logic              ser_load;
    logic              ser_shift;
    logic [UNIT_W-1:0] ser_unit;
    logic              ser_last;
    word_t             rd_word;

    // Memory array: no reset, contents survive reset_n.
    always_ff @(posedge clock) begin
        if (wr) begin
            memblock[waddr] <= wdata;
        end
    end

    // Read is taken from the current array contents, so a same-cycle write to
    // the bank being loaded lands after the snapshot (read before write).
    assign rd_word = memblock[bank];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            bank  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            bank  <= bank_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        bank_next  = bank;
        done_next  = 1'b0;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    bank_next  = '0;
                end
            end
            LOAD: begin
                ser_load   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        if (bank == BANK_W'(NB - 1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            bank_next  = bank + BANK_W'(1);
                            state_next = LOAD;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    nib_serializer u_ser (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ser_load),
        .load_data (rd_word),
        .shift     (ser_shift),
        .nib       (odata),
        .unit      (ser_unit),
        .last      (ser_last)
    );

    // Decoded straight from the state register so that reset drops them
    // asynchronously.
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign oaddr     = unit_addr(bank, ser_unit);

endmodule
